// File: rtl/conv_mem_host.sv
// conv_mem_host: host-side memory wrapper for a convolution engine.
// Holds the input image plus the layer-0/1/2 result banks, sequences the
// load -> arm -> run -> done handshake, and flags illegal engine accesses.
module conv_mem_host #(
  parameter int DW       = 20,
  parameter int IMG_AW   = 12,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              err,
  input  logic              ld_valid,
  input  logic [DW-1:0]     ld_data,
  output logic              ld_ready,
  input  logic [2:0]        dump_sel,
  input  logic [IMG_AW-1:0] dump_addr,
  output logic [DW-1:0]     dump_data,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic [2:0]        csel,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  output logic [15:0]       wr_count
);

  localparam int IMG_DEPTH = 1 << IMG_AW;
  localparam int L1_AW     = $clog2(L1_DEPTH);
  localparam int L2_AW     = $clog2(L2_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

  // Storage is never reset; contents survive reset and re-runs.
  logic [DW-1:0] img_mem  [IMG_DEPTH];
  logic [DW-1:0] l0k0_mem [IMG_DEPTH];
  logic [DW-1:0] l0k1_mem [IMG_DEPTH];
  logic [DW-1:0] l1k0_mem [L1_DEPTH];
  logic [DW-1:0] l1k1_mem [L1_DEPTH];
  logic [DW-1:0] l2_mem   [L2_DEPTH];

  state_t            state_q;
  logic              ready_q, done_q, err_q, ld_ready_q, busy_q;
  logic [15:0]       wr_count_q;
  logic [IMG_AW-1:0] load_ptr_q;

  logic ld_acc, wr_ok, acc_bad;

  // Bank select 1..5 is legal; L1/L2 additionally bound the address.
  function automatic logic addr_ok(input logic [2:0] sel, input logic [IMG_AW-1:0] a);
    case (sel)
      3'd1, 3'd2: return 1'b1;
      3'd3, 3'd4: return int'(a) < L1_DEPTH;
      3'd5:       return int'(a) < L2_DEPTH;
      default:    return 1'b0;
    endcase
  endfunction

  // Illegal selections or addresses read as zero.
  function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [IMG_AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    if (addr_ok(sel, a)) begin
      case (sel)
        3'd1:    r = l0k0_mem[a];
        3'd2:    r = l0k1_mem[a];
        3'd3:    r = l1k0_mem[a[L1_AW-1:0]];
        3'd4:    r = l1k1_mem[a[L1_AW-1:0]];
        3'd5:    r = l2_mem[a[L2_AW-1:0]];
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Access qualification; reset blocks any write on the edge it is sampled.
  always_comb begin
    ld_acc  = !reset && (state_q == S_LOAD) && ld_valid;
    wr_ok   = !reset && cwr && (state_q == S_RUN) && addr_ok(csel, caddr_wr);
    acc_bad = (cwr && !((state_q == S_RUN) && addr_ok(csel, caddr_wr))) ||
              (crd && !addr_ok(csel, caddr_rd));
  end

  // Zero-latency read ports; a same-edge write is seen only next cycle.
  always_comb begin
    idata     = img_mem[iaddr];
    cdata_rd  = crd ? bank_rd(csel, caddr_rd) : '0;
    dump_data = (dump_sel == 3'd0) ? img_mem[dump_addr] : bank_rd(dump_sel, dump_addr);
  end

  // Image load and engine write ports.
  always_ff @(posedge clk) begin
    if (ld_acc) img_mem[load_ptr_q] <= ld_data;
    if (wr_ok) begin
      case (csel)
        3'd1:    l0k0_mem[caddr_wr] <= cdata_wr;
        3'd2:    l0k1_mem[caddr_wr] <= cdata_wr;
        3'd3:    l1k0_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd4:    l1k1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd5:    l2_mem[caddr_wr[L2_AW-1:0]] <= cdata_wr;
        default: ;
      endcase
    end
  end

  // Sequencing FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
      load_ptr_q <= '0;
    end else begin
      busy_q <= busy;
      if (acc_bad) err_q <= 1'b1;
      if (wr_ok && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_LOAD;
          ld_ready_q <= 1'b1;
        end
        S_LOAD: if (ld_valid) begin
          load_ptr_q <= load_ptr_q + 1'b1;
          if (load_ptr_q == {IMG_AW{1'b1}}) begin
            state_q    <= S_ARM;
            ld_ready_q <= 1'b0;
            ready_q    <= 1'b1;
          end
        end
        S_ARM: if (busy) begin
          state_q <= S_RUN;
          ready_q <= 1'b0;
        end
        // Only a 1->0 edge of busy ends the run.
        S_RUN: if (busy_q && !busy) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: if (start) begin
          state_q    <= S_LOAD;
          ld_ready_q <= 1'b1;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          wr_count_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ld_ready = ld_ready_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Scoreboard bench for conv_mem_host: the driver pushes expectations taken
// from a plain-array model; a negedge monitor pops and compares them.
module tb_conv_mem_host;
  localparam int DW  = 20;
  localparam int L1D = 1024;
  localparam int L2D = 2048;
  localparam int K_IDATA = 0, K_CRD = 1, K_DUMP = 2, K_READY = 3,
                 K_DONE = 4, K_ERR = 5, K_LDRDY = 6, K_WRCNT = 7;

  logic clk = 1'b0, reset, start, done, err, ld_valid, ld_ready, ready, busy;
  logic cwr, crd;
  logic [DW-1:0] ld_data, dump_data, idata, cdata_wr, cdata_rd;
  logic [2:0] dump_sel, csel;
  logic [11:0] dump_addr, iaddr, caddr_wr, caddr_rd;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  conv_mem_host #(.DW(DW), .IMG_AW(12), .L1_DEPTH(L1D), .L2_DEPTH(L2D)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .err(err),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .wr_count(wr_count));

  typedef struct {int cyc; int kind; logic [31:0] exp; string nm;} item_t;
  item_t sbq[$];
  int cyc = 0, checks = 0, errors = 0;

  // reference model
  logic [DW-1:0] m_img [4096];
  logic [DW-1:0] m_bank [int];
  int  m_wr = 0;
  bit  m_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(int k);
    case (k)
      K_IDATA: return 32'(idata);
      K_CRD:   return 32'(cdata_rd);
      K_DUMP:  return 32'(dump_data);
      K_READY: return 32'(ready);
      K_DONE:  return 32'(done);
      K_ERR:   return 32'(err);
      K_LDRDY: return 32'(ld_ready);
      default: return 32'(wr_count);
    endcase
  endfunction

  // monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        logic [31:0] a;
        a = dut_val(sbq[i].kind);
        checks++;
        if (sbq[i].cyc < cyc || a !== sbq[i].exp) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", sbq[i].nm, cyc, a, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic push(int dc, int k, logic [31:0] e, string nm);
    item_t it;
    it.cyc = cyc + dc; it.kind = k; it.exp = e; it.nm = nm;
    sbq.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit m_ok(int sel, int a);
    case (sel)
      1, 2:    return 1'b1;
      3, 4:    return a < L1D;
      5:       return a < L2D;
      default: return 1'b0;
    endcase
  endfunction

  task automatic exp_bank(int k, int sel, int a, string nm);
    if (k == K_DUMP && sel == 0) push(0, k, 32'(m_img[a]), nm);
    else if (!m_ok(sel, a)) push(0, k, 0, nm);
    else if (m_bank.exists(sel * 8192 + a)) push(0, k, 32'(m_bank[sel * 8192 + a]), nm);
  endtask

  task automatic status(bit rdy, bit dn, bit ldr);
    push(0, K_READY, 32'(rdy), "ready");
    push(0, K_DONE, 32'(dn), "done");
    push(0, K_LDRDY, 32'(ldr), "ld_ready");
    push(0, K_ERR, 32'(m_err), "err");
    push(0, K_WRCNT, 32'(m_wr), "wr_count");
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 15);
      1:       return $urandom_range(L1D - 24, L1D + 24);
      2:       return $urandom_range(L2D - 24, L2D + 24);
      default: return $urandom_range(0, 4095);
    endcase
  endfunction

  // one engine access cycle; model read happens before the model write
  task automatic op(bit w, bit r, int sel, int wa, int ra, logic [DW-1:0] d, bit in_run);
    int dsel, da;
    cwr = w; crd = r; csel = 3'(sel);
    caddr_wr = 12'(wa); caddr_rd = 12'(ra); cdata_wr = d;
    dsel = $urandom_range(0, 7);
    da = $urandom_range(0, 1) ? ra : $urandom_range(0, 4095);
    dump_sel = 3'(dsel); dump_addr = 12'(da);
    if (r) exp_bank(K_CRD, sel, ra, "cdata_rd");
    else push(0, K_CRD, 0, "cdata_rd_idle");
    exp_bank(K_DUMP, dsel, da, "dump_data");
    if (w && !(in_run && m_ok(sel, wa))) m_err = 1;
    if (r && !m_ok(sel, ra)) m_err = 1;
    if (w && in_run && m_ok(sel, wa)) begin
      m_bank[sel * 8192 + wa] = d;
      if (m_wr < 65535) m_wr++;
    end
    tick();
    cwr = 0; crd = 0;
    push(0, K_ERR, 32'(m_err), "err");
    push(0, K_WRCNT, 32'(m_wr), "wr_count");
  endtask

  task automatic dump_chk(int sel, int a);
    dump_sel = 3'(sel); dump_addr = 12'(a);
    exp_bank(K_DUMP, sel, a, "dump_chk");
    tick();
  endtask

  // feeds 4096 words with random gaps; returns in the first ARM cycle
  task automatic load_image(bit use_addr);
    int n = 0;
    while (n < 4096) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data = use_addr ? DW'(n) : DW'($urandom);
      if (n % 512 == 0) begin
        push(0, K_LDRDY, 1, "ld_ready_load");
        push(0, K_READY, 0, "ready_load");
      end
      if (ld_valid) begin
        m_img[n] = ld_data;
        if (n == 4095) begin
          push(1, K_LDRDY, 0, "ld_ready_fall");
          push(1, K_READY, 1, "ready_rise");
        end
        n++;
      end
      tick();
    end
    ld_valid = 0;
  endtask

  // three ARM cycles with stray ld_valid, then busy; returns in first RUN cycle
  task automatic handshake(int first_iaddr);
    for (int k = 0; k < 3; k++) begin
      push(0, K_READY, 1, "ready_arm");
      push(0, K_LDRDY, 0, "ld_ready_arm");
      iaddr = (k == 0) ? 12'(first_iaddr) : 12'h000;
      push(0, K_IDATA, 32'(m_img[iaddr]), "idata_arm");
      ld_valid = 1; ld_data = DW'($urandom);
      tick();
    end
    ld_valid = 0; busy = 1;
    push(0, K_READY, 1, "ready_busy_cycle");
    tick();
    push(0, K_READY, 0, "ready_after_busy");
    push(0, K_DONE, 0, "done_run");
  endtask

  initial begin
    logic [DW-1:0] v;
    int sel, wa;
    reset = 1; start = 0; ld_valid = 0; ld_data = '0; busy = 0;
    iaddr = '0; cwr = 0; crd = 0; csel = '0; caddr_wr = '0; caddr_rd = '0;
    cdata_wr = '0; dump_sel = '0; dump_addr = '0;
    repeat (3) tick();
    reset = 0;
    status(0, 0, 0);
    // IDLE: load port and engine write are rejected/ignored
    ld_valid = 1; ld_data = 20'h5;
    tick();
    ld_valid = 0;
    push(0, K_LDRDY, 0, "ld_ready_idle");
    start = 1;
    tick();
    start = 0;
    status(0, 0, 1);

    load_image(1);
    handshake(12'h0A5);

    // directed RUN accesses
    op(1, 0, 1, 12'h041, 0, 20'h12345, 1);
    op(0, 1, 1, 0, 12'h041, '0, 1);
    op(1, 0, 3, 5, 0, 20'h00007, 1);
    op(1, 1, 3, 5, 5, 20'h00009, 1);
    op(0, 1, 3, 0, 5, '0, 1);
    op(1, 0, 3, 0, 0, 20'h00ABC, 1);
    op(1, 0, 6, 0, 0, 20'h11111, 1);
    op(1, 0, 3, 12'h400, 0, 20'h22222, 1);
    dump_chk(3, 0);
    op(1, 1, 5, 12'h7FF, 12'h800, 20'h33333, 1);

    // random RUN traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      wa = rand_addr();
      op($urandom_range(0, 1), $urandom_range(0, 1), sel, wa,
         $urandom_range(0, 1) ? wa : rand_addr(), DW'($urandom), 1);
    end

    busy = 0;
    tick();
    status(0, 1, 0);
    op(1, 0, 1, 3, 0, DW'($urandom), 0);
    start = 1;
    tick();
    start = 0;
    m_err = 0; m_wr = 0;
    status(0, 0, 1);
    dump_chk(1, 12'h041);

    load_image(0);
    handshake($urandom_range(0, 4095));
    op(1, 0, 1, 7, 0, 20'h0BEEF, 1);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      wa = rand_addr();
      op($urandom_range(0, 1), $urandom_range(0, 1), sel, wa, wa, DW'($urandom), 1);
    end

    // reset in RUN with a legal write on the same edge: write is dropped
    reset = 1; cwr = 1; csel = 3'd1; caddr_wr = 12'h007; cdata_wr = 20'h5A5A5;
    tick();
    reset = 0; cwr = 0;
    m_wr = 0; m_err = 0;
    status(0, 0, 0);
    dump_chk(1, 7);
    start = 1;
    tick();
    start = 0;
    status(0, 0, 1);
    v = ~m_img[0];
    ld_valid = 1; ld_data = v; m_img[0] = v;
    tick();
    ld_valid = 0;
    iaddr = 12'h000;
    push(0, K_IDATA, 32'(v), "idata_reload_ptr0");
    tick();
    tick();

    if (sbq.size() != 0) begin
      errors += sbq.size();
      $display("FAIL scoreboard: %0d expectations never compared", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
